// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller behind the CPU MIO port: word RAM with wait states,
// a small IO page (LEDs, switches, timer) and a sticky timer-compare interrupt.
module mio_bus_ctrl #(
  parameter int RAM_AW   = 10,
  parameter int RAM_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] Addr_out,
  input  logic [31:0] Data_out,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  output logic        INT,
  input  logic [15:0] sw,
  output logic [15:0] led
);
  localparam int WW = (RAM_WAIT > 0) ? $clog2(RAM_WAIT + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [31:0]   addr_q, wdata_q;
  logic          we_q;
  logic [31:0]   dout_q, count_q, cmp_q;
  logic [15:0]   led_q;
  logic          int_q;
  logic [31:0]   ram [0:(2**RAM_AW)-1];

  logic [31:0]       acc_addr, acc_wdata, rd_data;
  logic              acc_we, acc_io, req_io, go_ack, wr_fire;
  logic              led_wr, cmp_wr, ram_we;
  logic [27:0]       io_off;
  logic [RAM_AW-1:0] acc_idx;

  assign req_io = (Addr_out[31:28] == 4'hF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: if (CPU_MIO) begin
        if (req_io || RAM_WAIT == 0) state_d = ACK;
        else begin
          state_d = WAIT;
          wcnt_d  = WW'(RAM_WAIT);
        end
      end
      WAIT: begin
        if (wcnt_q == WW'(1)) state_d = ACK;
        else                  wcnt_d  = wcnt_q - WW'(1);
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    MIO_ready = (state_q == ACK);
    Data_in   = dout_q;
    led       = led_q;
    INT       = int_q;
  end

  // Accesses that go straight from IDLE to ACK commit on the sampling edge,
  // so the live bus is used there instead of the latched copy.
  always_comb begin
    acc_addr  = (state_q == IDLE) ? Addr_out : addr_q;
    acc_wdata = (state_q == IDLE) ? Data_out : wdata_q;
    acc_we    = (state_q == IDLE) ? mem_w    : we_q;
    acc_io    = (acc_addr[31:28] == 4'hF);
    io_off    = acc_addr[27:0];
    acc_idx   = acc_addr[RAM_AW+1:2];
    go_ack    = (state_q != ACK) && (state_d == ACK);
    wr_fire   = go_ack && acc_we;
    led_wr    = wr_fire && acc_io && (io_off == 28'h0);
    cmp_wr    = wr_fire && acc_io && (io_off == 28'hC);
    ram_we    = wr_fire && !acc_io;
    rd_data   = '0;
    if (acc_io) begin
      unique case (io_off)
        28'h0:   rd_data = {16'h0, led_q};
        28'h4:   rd_data = {16'h0, sw};
        28'h8:   rd_data = count_q;
        28'hC:   rd_data = cmp_q;
        default: rd_data = '0;
      endcase
    end else begin
      rd_data = ram[acc_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      dout_q  <= '0;
      led_q   <= '0;
      count_q <= '0;
      cmp_q   <= '1;
      int_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && CPU_MIO) begin
        addr_q  <= Addr_out;
        wdata_q <= Data_out;
        we_q    <= mem_w;
      end
      if (go_ack && !acc_we) dout_q <= rd_data;
      if (led_wr)            led_q  <= acc_wdata[15:0];
      count_q <= count_q + 32'd1;
      // A compare write overrides a match landing on the same edge.
      if (cmp_wr) begin
        cmp_q <= acc_wdata;
        int_q <= 1'b0;
      end else if (count_q == cmp_q) begin
        int_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[acc_idx] <= acc_wdata;
  end
endmodule
